aes_enc_arbiter: RTL

Shares one AES-128 encryption core between two requesters: port 0 is the PicoRV32 PCPI co-processor path and port 1 is the bulk/DMA path. Requests use a valid/ack handshake. The block applies round-robin arbitration, latches the winner's plaintext and key, and issues a one-cycle start pulse to the core. It then waits for the core's done and returns the ciphertext to the granted requester. It sits between the requesters and the encryption core and is the only driver of the core's start, plaintext and key inputs.

---
 rtl/aes_arb_pkg.sv | 20 ++
 rtl/aes_rr_arbiter2.sv | 47 ++++
 rtl/aes_enc_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_arb_pkg.sv
// Shared definitions for the AES-128 encryption-core arbiter.
//   arb_state_e : arbiter FSM encoding
//   AES_W       : plaintext / key / ciphertext width
//   REQ_PCPI    : requester ID of the PicoRV32 PCPI path (port 0)
//   REQ_DMA     : requester ID of the bulk/DMA path (port 1)
package aes_arb_pkg;

  localparam int AES_W = 128;

  localparam logic REQ_PCPI = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/aes_rr_arbiter2.sv
// Two-way round-robin grant with the pointer updated only when the grant is
// accepted. Reusable for any co-processor shared between two requesters.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   req[1:0]      : request vector (bit N = requester N)
//   accept        : caller takes the current grant; pointer moves
//   grant_valid   : at least one request is present
//   grant_id      : winning requester (valid with grant_valid)
module aes_rr_arbiter2
  import aes_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant_id
);

  // Last requester served; reset to DMA so that PCPI wins the first tie.
  logic last_q, last_d;

  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_PCPI;
    unique case (req)
      2'b01:   grant_id = REQ_PCPI;
      2'b10:   grant_id = REQ_DMA;
      2'b11:   grant_id = ~last_q;
      default: grant_id = REQ_PCPI;
    endcase

    last_d = last_q;
    if (accept && grant_valid) begin
      last_d = grant_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= REQ_DMA;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/aes_enc_arbiter.sv
// Shares one AES-128 encryption core between the PCPI requester (port 0) and
// the DMA requester (port 1). Grants round-robin, latches the winner's
// plaintext/key, pulses core_encrypt, waits for a rising core_done and returns
// the ciphertext to the owner. All outputs are registered.
// Ports:
//   clock, reset                   : rising-edge clock, sync active-high reset
//   reqN_valid/_plain/_key/_ack    : requester N job handshake (N = 0, 1)
//   rsp_data, rsp0_valid, rsp1_valid, rsp_err : response to the owner
//   busy                           : grant through response pulse, inclusive
//   core_encrypt/_plain/_key       : start pulse and operands to the core
//   core_done, core_dout           : core completion level and ciphertext
// Optional feature macro: AES_ARB_TIMEOUT_EN -- WAIT watchdog; on expiry the
// owner gets rsp_err=1 with rsp_data=0. Without it rsp_err is tied low.
//
// state | meaning
// IDLE  | no job; grant a pending request
// ISSUE | operands latched, core_encrypt high this cycle
// WAIT  | waiting for a rising edge of core_done
// RESP  | rspN_valid pulse to the owner
module aes_enc_arbiter
  import aes_arb_pkg::*;
#(
  parameter int DATA_W         = AES_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_plain,
  input  logic [DATA_W-1:0] req0_key,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_plain,
  input  logic [DATA_W-1:0] req1_key,
  output logic              req1_ack,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic              rsp_err,
  output logic              busy,
  output logic              core_encrypt,
  output logic [DATA_W-1:0] core_plain,
  output logic [DATA_W-1:0] core_key,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_dout
);

  if (DATA_W != AES_W) begin : g_bad_data_w
    $error("aes_enc_arbiter: DATA_W is fixed at 128");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("aes_enc_arbiter: TIMEOUT_CYCLES out of range");
  end

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] plain_q, plain_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              owner_q, owner_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              rsp0_q, rsp0_d;
  logic              rsp1_q, rsp1_d;
  logic              busy_q, busy_d;
  logic              enc_q, enc_d;
  logic              done_prev_q, done_prev_d;
  logic              done_rise;
  logic              grant_valid, grant_id, accept;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  aes_rr_arbiter2 u_rr (
    .clock       (clock),
    .reset       (reset),
    .req         ({req1_valid, req0_valid}),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // A done level held over from the previous job must not complete this one.
  assign done_rise = core_done & ~done_prev_q;

  always_comb begin
    state_d     = state_q;
    plain_d     = plain_q;
    key_d       = key_q;
    rsp_data_d  = rsp_data_q;
    owner_d     = owner_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rsp0_d      = 1'b0;
    rsp1_d      = 1'b0;
    enc_d       = 1'b0;
    busy_d      = busy_q;
    accept      = 1'b0;
    done_prev_d = core_done;
`ifdef AES_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          accept  = 1'b1;
          owner_d = grant_id;
          ack0_d  = (grant_id == REQ_PCPI);
          ack1_d  = (grant_id == REQ_DMA);
          plain_d = (grant_id == REQ_DMA) ? req1_plain : req0_plain;
          key_d   = (grant_id == REQ_DMA) ? req1_key : req0_key;
          busy_d  = 1'b1;
          enc_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (done_rise) begin
          rsp_data_d = core_dout;
          rsp0_d     = (owner_q == REQ_PCPI);
          rsp1_d     = (owner_q == REQ_DMA);
          state_d    = RESP;
        end
`ifdef AES_ARB_TIMEOUT_EN
        // cnt_d is the number of WAIT cycles including this one.
        else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          rsp0_d     = (owner_q == REQ_PCPI);
          rsp1_d     = (owner_q == REQ_DMA);
          state_d    = RESP;
        end
`endif
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      plain_q     <= '0;
      key_q       <= '0;
      rsp_data_q  <= '0;
      owner_q     <= REQ_PCPI;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
      busy_q      <= 1'b0;
      enc_q       <= 1'b0;
      done_prev_q <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      plain_q     <= plain_d;
      key_q       <= key_d;
      rsp_data_q  <= rsp_data_d;
      owner_q     <= owner_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rsp0_q      <= rsp0_d;
      rsp1_q      <= rsp1_d;
      busy_q      <= busy_d;
      enc_q       <= enc_d;
      done_prev_q <= done_prev_d;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign req0_ack     = ack0_q;
  assign req1_ack     = ack1_q;
  assign rsp_data     = rsp_data_q;
  assign rsp0_valid   = rsp0_q;
  assign rsp1_valid   = rsp1_q;
  assign busy         = busy_q;
  assign core_encrypt = enc_q;
  assign core_plain   = plain_q;
  assign core_key     = key_q;
`ifdef AES_ARB_TIMEOUT_EN
  assign rsp_err      = err_q;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule
